// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that time-shares one bit-serial overlapping "1011" Mealy
// detector across NCH channels. Optional macro SEQ_SCHED_EARLY_EXIT_EN ends a job at its first match.
module seq_detect_scheduler #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*W-1:0]         data_in,
  output logic [NCH-1:0]           grant,
  output logic                     busy,
  output logic                     det_in,
  output logic                     det_out,
  output logic                     done,
  output logic [$clog2(NCH)-1:0]   done_ch,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int CHW = $clog2(NCH);
  localparam int BW  = $clog2(W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [1:0] S0    = 2'd0;
  localparam logic [1:0] S1    = 2'd1;
  localparam logic [1:0] S10   = 2'd2;
  localparam logic [1:0] S101  = 2'd3;

  logic [1:0]              state;
  logic [1:0]              dstate;
  logic [1:0]              dstate_nxt;
  logic [CHW-1:0]          ptr;
  logic [CHW-1:0]          gidx;
  logic [NCH-1:0]          grant_q;
  logic [W-1:0]            sreg;
  logic [BW-1:0]           bcnt;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [CHW-1:0]          done_ch_q;
  logic [CNT_W-1:0]        match_cnt_q;
  logic                    sel_vld;
  logic [CHW-1:0]          sel_idx;
  logic                    last_bit;
  logic                    exit_now;
  logic [NCH-1:0][W-1:0]   words;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign words[k] = data_in[k*W +: W];
  end

  // Scan offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NCH]) begin
        sel_vld = 1'b1;
        sel_idx = CHW'((int'(ptr) + i) % NCH);
      end
    end
  end

  assign det_in  = (state == SHIFT) & sreg[W-1];
  assign det_out = (state == SHIFT) & (dstate == S101) & det_in;

  always_comb begin
    dstate_nxt = S0;
    case (dstate)
      S0:      dstate_nxt = det_in ? S1   : S0;
      S1:      dstate_nxt = det_in ? S1   : S10;
      S10:     dstate_nxt = det_in ? S101 : S0;
      S101:    dstate_nxt = det_in ? S1   : S10;
      default: dstate_nxt = S0;
    endcase
  end

  assign cnt_nxt  = (det_out && cnt != {CNT_W{1'b1}}) ? cnt + 1'b1 : cnt;
  assign last_bit = (bcnt == BW'(W-1));

`ifdef SEQ_SCHED_EARLY_EXIT_EN
  assign exit_now = last_bit | det_out;
`else
  assign exit_now = last_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dstate      <= S0;
      ptr         <= '0;
      gidx        <= '0;
      grant_q     <= '0;
      sreg        <= '0;
      bcnt        <= '0;
      cnt         <= '0;
      done_ch_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant_q <= NCH'(1) << sel_idx;
            gidx    <= sel_idx;
            sreg    <= words[sel_idx];
            bcnt    <= '0;
            cnt     <= '0;
            dstate  <= S0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          sreg   <= sreg << 1;
          bcnt   <= bcnt + 1'b1;
          cnt    <= cnt_nxt;
          dstate <= dstate_nxt;
          if (exit_now) begin
            // Capture the final count including the bit on this edge.
            match_cnt_q <= cnt_nxt;
            done_ch_q   <= gidx;
            state       <= REPORT;
          end
        end
        REPORT: begin
          grant_q <= '0;
          dstate  <= S0;
          ptr     <= (gidx == CHW'(NCH-1)) ? '0 : gidx + 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign busy      = (state == SHIFT) | (state == REPORT);
  assign done      = (state == REPORT);
  assign done_ch   = done_ch_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: stimulus queues expected done reports,
// a negedge monitor pops and compares each done pulse.
module tb_seq_detect_scheduler;
  localparam int NCH = 4;
  localparam int W = 8;
  localparam int CNT_W = 4;

`ifdef SEQ_SCHED_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  // Hand-derived results: 1011_0110 matches at bits 3,6; 1011_1011 at bits 3,7;
  // 1011_1101 at bit 3 only.
  localparam int CNT_A = EE ? 1 : 2;
  localparam int CNT_B = EE ? 1 : 2;
  localparam int CNT_C = 1;
  localparam int JC    = EE ? 5 : 9;
  localparam int JC_Z  = 9;
  localparam int DET_A = EE ? 8'h08 : 8'h48;

  typedef struct packed {
    logic [1:0] ch;
    logic [3:0] cnt;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic [NCH-1:0]       req;
  logic [NCH*W-1:0]     data_in;
  logic [NCH-1:0]       grant;
  logic                 busy;
  logic                 det_in;
  logic                 det_out;
  logic                 done;
  logic [1:0]           done_ch;
  logic [CNT_W-1:0]     match_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  exp_t sb_q[$];
  int   done_at[$];
  exp_t e;

  seq_detect_scheduler #(.NCH(NCH), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in), .grant(grant),
    .busy(busy), .det_in(det_in), .det_out(det_out), .done(done),
    .done_ch(done_ch), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      done_at.push_back(cyc_no);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done ch=%0d cnt=%0d expected=none", done_ch, match_cnt);
      end else begin
        e = sb_q.pop_front();
        chk("done_ch", done_ch, e.ch);
        chk("match_cnt", match_cnt, e.cnt);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [W-1:0] v);
    data_in[k*W +: W] = v;
  endtask

  task automatic push_exp(input int ch, input int cnt);
    exp_t x;
    x.ch  = 2'(ch);
    x.cnt = 4'(cnt);
    sb_q.push_back(x);
  endtask

  task automatic wait_grant(output logic [NCH-1:0] g);
    int i = 0;
    while (grant == '0 && i < 30) begin
      tick();
      i++;
    end
    if (grant == '0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=0 expected=nonzero");
    end
    g = grant;
  endtask

  task automatic hold_job(output int n, output logic [31:0] dv);
    n  = 0;
    dv = '0;
    while (grant != '0 && n < 40) begin
      if (n < 32) dv[n] = det_out;
      n++;
      tick();
    end
  endtask

  logic [NCH-1:0] g;
  logic [31:0]    dv;
  int             n;

  initial begin
    reset = 1'b1;
    req = '0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_det_in", det_in, 0);
    chk("rst_det_out", det_out, 0);
    chk("rst_done", done, 0);
    chk("rst_done_ch", done_ch, 0);
    chk("rst_match_cnt", match_cnt, 0);
    @(negedge clk) reset = 1'b0;

    // Overlap path on ch0; req dropped right after grant
    set_word(0, 8'b1011_0110);
    push_exp(0, CNT_A);
    req = 4'b0001;
    wait_grant(g);
    chk("t1_grant", g, 4'b0001);
    chk("t1_busy", busy, 1);
    req = '0;
    hold_job(n, dv);
    chk("t1_cycles", n, JC);
    chk("t1_det_out", dv[7:0], DET_A);
    chk("t1_cnt_hold", match_cnt, CNT_A);
    chk("t1_idle_busy", busy, 0);

    // All-zero then all-one word on ch1; data change mid-job ignored
    set_word(1, 8'h00);
    push_exp(1, 0);
    req = 4'b0010;
    wait_grant(g);
    chk("t2a_grant", g, 4'b0010);
    set_word(1, 8'hFF);
    req = '0;
    hold_job(n, dv);
    chk("t2a_cycles", n, JC_Z);
    chk("t2a_det_out", dv, 0);
    push_exp(1, 0);
    req = 4'b0010;
    wait_grant(g);
    chk("t2b_grant", g, 4'b0010);
    req = '0;
    hold_job(n, dv);
    chk("t2b_cycles", n, JC_Z);
    chk("t2b_det_out", dv, 0);

    // Pointer at 2: ch0 wins by wrap, then strict alternation
    set_word(0, 8'b1011_0110);
    set_word(1, 8'b1011_1101);
    for (int j = 0; j < 4; j++) push_exp(j % 2, (j % 2) ? CNT_C : CNT_A);
    req = 4'b0011;
    for (int j = 0; j < 4; j++) begin
      wait_grant(g);
      chk("t4_grant", g, 1 << (j % 2));
      if (j == 3) req = '0;
      hold_job(n, dv);
      chk("t4_cycles", n, JC);
    end

    // Fresh reset: full rotation from ch0, fixed done spacing
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NCH; k++) set_word(k, 8'b1011_1011);
    for (int j = 0; j < 5; j++) push_exp(j % 4, CNT_B);
    done_at.delete();
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_grant(g);
      chk("t3_grant", g, 1 << (j % 4));
      if (j == 4) req = '0;
      hold_job(n, dv);
      chk("t3_cycles", n, JC);
    end
    chk("t3_done_count", done_at.size(), 5);
    for (int i = 0; i + 1 < done_at.size(); i++)
      chk("t3_done_spacing", done_at[i+1] - done_at[i], JC + 1);

    // Reset at bit 4 of a ch2 job: no done for the aborted job
    set_word(2, 8'b1011_0110);
    req = 4'b0100;
    wait_grant(g);
    chk("t5_grant", g, 4'b0100);
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    push_exp(2, CNT_A);
    wait_grant(g);
    chk("t5_regrant", g, 4'b0100);
    req = '0;
    hold_job(n, dv);
    chk("t5_cycles", n, JC);

    // Early-exit sensitive word on ch0
    set_word(0, 8'b1011_1011);
    push_exp(0, CNT_B);
    req = 4'b0001;
    wait_grant(g);
    chk("t6_grant", g, 4'b0001);
    req = '0;
    hold_job(n, dv);
    chk("t6_cycles", n, JC);

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
